// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage of the pipelined MIPS core. It owns the program
// counter, drives the combinational instruction-memory read, and loads the
// IF/ID pipeline register with {PC+4, instruction, valid}.
//
// Each edge does exactly one of the following, checked in this order:
//   reset    -> return to RESET_PC and clear IF/ID and both counters
//   redirect -> load the aligned target and squash IF/ID to a bubble
//   stall    -> hold pc and IF/ID
//   advance  -> fetch the next sequential instruction
//
// Ports:
//   clk           rising-edge clock
//   reset         synchronous, active-high reset
//   stall         hazard unit: hold pc and IF/ID this cycle
//   redirect      execute stage: taken branch/jump, load redirect_pc
//   redirect_pc   target address, bits [1:0] ignored
//   imem_addr     instruction memory address (equals pc)
//   imem_rdata    instruction word at imem_addr, same cycle
//   pc            current fetch PC
//   ifid_pc4      PC+4 of the instruction held in IF/ID
//   ifid_instr    instruction held in IF/ID
//   ifid_valid    1 = real instruction, 0 = bubble
//   stall_count   saturating count of stall cycles that were not redirects
//   bubble_count  saturating count of redirect squashes
// ----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             redirect,
    input  logic [31:0]      redirect_pc,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      pc,
    output logic [31:0]      ifid_pc4,
    output logic [31:0]      ifid_instr,
    output logic             ifid_valid,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] bubble_count
);

    localparam logic [31:0]      ALIGN_MASK = 32'hFFFF_FFFC;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    logic [31:0] pc_plus4;

    // Wraps naturally: 32'hFFFF_FFFC + 4 = 0.
    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = pc;

    // pc and IF/ID share one priority mux: reset > redirect > stall > advance.
    // NOTE: state is written with non-blocking assignments so every register
    // samples the pre-edge values; blocking here would let pc_plus4 consumers
    // see a half-updated pc in simulation and diverge from the netlist.
    always_ff @(posedge clk) begin
        if (reset) begin
            // Masking keeps pc[1:0] at 0 even if RESET_PC is misconfigured.
            pc         <= RESET_PC & ALIGN_MASK;
            ifid_pc4   <= 32'h0;
            ifid_instr <= NOP_INSTR;
            ifid_valid <= 1'b0;
        end else if (redirect) begin
            // Misaligned targets are silently aligned; no exception exists.
            pc         <= redirect_pc & ALIGN_MASK;
            ifid_pc4   <= 32'h0;
            ifid_instr <= NOP_INSTR;
            ifid_valid <= 1'b0;
        end else if (!stall) begin
            pc         <= pc_plus4;
            ifid_pc4   <= pc_plus4;
            ifid_instr <= imem_rdata;
            ifid_valid <= 1'b1;
        end
        // stall with no redirect: everything above holds.
    end

    // Performance counters. A redirect that coincides with a stall counts
    // only as a bubble, matching the priority of the datapath above.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count  <= '0;
            bubble_count <= '0;
        end else if (redirect) begin
            if (bubble_count != CNT_MAX) begin
                bubble_count <= bubble_count + CNT_ONE;
            end
        end else if (stall) begin
            if (stall_count != CNT_MAX) begin
                stall_count <= stall_count + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// ----------------------------------------------------------------------------
// tb_fetch_stage
//
// Self-checking bench for fetch_stage. Two instances share the same stimulus:
// one with the default 16-bit counters and one with 2-bit counters so that
// saturation is reachable. The instruction memory returns addr ^ MEM_KEY.
// A behavioural model tracks pc, IF/ID and unbounded event counts; expected
// counter values are the counts clamped to the counter range.
// ----------------------------------------------------------------------------
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] MEM_KEY   = 32'hA5A5_0000;
    localparam int          W_BIG     = 16;
    localparam int          W_SMALL   = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;

    logic [31:0]        a_imem_addr, a_imem_rdata, a_pc, a_ifid_pc4, a_ifid_instr;
    logic               a_ifid_valid;
    logic [W_BIG-1:0]   a_stall_count, a_bubble_count;

    logic [31:0]        b_imem_addr, b_imem_rdata, b_pc, b_ifid_pc4, b_ifid_instr;
    logic               b_ifid_valid;
    logic [W_SMALL-1:0] b_stall_count, b_bubble_count;

    always #5 clk = ~clk;

    // Combinational instruction memory.
    assign a_imem_rdata = a_imem_addr ^ MEM_KEY;
    assign b_imem_rdata = b_imem_addr ^ MEM_KEY;

    fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR), .CNT_W(W_BIG)) dut_a (
        .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_addr(a_imem_addr), .imem_rdata(a_imem_rdata),
        .pc(a_pc), .ifid_pc4(a_ifid_pc4), .ifid_instr(a_ifid_instr),
        .ifid_valid(a_ifid_valid), .stall_count(a_stall_count),
        .bubble_count(a_bubble_count)
    );

    fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR), .CNT_W(W_SMALL)) dut_b (
        .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_addr(b_imem_addr), .imem_rdata(b_imem_rdata),
        .pc(b_pc), .ifid_pc4(b_ifid_pc4), .ifid_instr(b_ifid_instr),
        .ifid_valid(b_ifid_valid), .stall_count(b_stall_count),
        .bubble_count(b_bubble_count)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    logic [31:0] m_pc, m_pc4, m_instr;
    logic        m_valid;
    int          m_stalls, m_bubbles;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] sat(input int n, input int w);
        int max_val;
        max_val = (1 << w) - 1;
        return (n > max_val) ? 32'(max_val) : 32'(n);
    endfunction

    // Drive one cycle of inputs, advance the model across the edge, compare.
    task automatic step(input logic r, input logic s, input logic rd, input logic [31:0] rpc);
        @(negedge clk);
        reset       = r;
        stall       = s;
        redirect    = rd;
        redirect_pc = rpc;
        @(posedge clk);
        if (r) begin
            m_pc      = RESET_PC;
            m_pc4     = 32'h0;
            m_instr   = NOP_INSTR;
            m_valid   = 1'b0;
            m_stalls  = 0;
            m_bubbles = 0;
        end else if (rd) begin
            m_pc      = {rpc[31:2], 2'b00};
            m_pc4     = 32'h0;
            m_instr   = NOP_INSTR;
            m_valid   = 1'b0;
            m_bubbles = m_bubbles + 1;
        end else if (s) begin
            m_stalls = m_stalls + 1;
        end else begin
            m_instr = m_pc ^ MEM_KEY;
            m_pc4   = m_pc + 32'd4;
            m_pc    = m_pc4;
            m_valid = 1'b1;
        end
        #1;
        check("pc",          a_pc,                  m_pc);
        check("imem_addr",   a_imem_addr,           m_pc);
        check("ifid_pc4",    a_ifid_pc4,            m_pc4);
        check("ifid_instr",  a_ifid_instr,          m_instr);
        check("ifid_valid",  32'(a_ifid_valid),     32'(m_valid));
        check("stall_cnt",   32'(a_stall_count),    sat(m_stalls, W_BIG));
        check("bubble_cnt",  32'(a_bubble_count),   sat(m_bubbles, W_BIG));
        check("s_pc",        b_pc,                  m_pc);
        check("s_ifid_pc4",  b_ifid_pc4,            m_pc4);
        check("s_stall_cnt", 32'(b_stall_count),    sat(m_stalls, W_SMALL));
        check("s_bubble_cnt",32'(b_bubble_count),   sat(m_bubbles, W_SMALL));
    endtask

    initial begin
        reset       = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        m_pc = 32'h0; m_pc4 = 32'h0; m_instr = 32'h0; m_valid = 1'b0;
        m_stalls = 0; m_bubbles = 0;

        // Reset, then free-run two edges.
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check("rst_pc",    a_pc, 32'h0);
        check("rst_valid", 32'(a_ifid_valid), 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("e1_instr", a_ifid_instr, 32'hA5A5_0000);
        check("e1_pc4",   a_ifid_pc4,   32'h4);
        check("e1_pc",    a_pc,         32'h4);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("e2_pc4",   a_ifid_pc4,   32'h8);
        check("e2_pc",    a_pc,         32'h8);

        // Three stall cycles at pc=8, then release.
        repeat (3) step(1'b0, 1'b1, 1'b0, 32'h0);
        check("st_pc",    a_pc,         32'h8);
        check("st_pc4",   a_ifid_pc4,   32'h8);
        check("st_cnt",   32'(a_stall_count), 32'd3);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("rel_pc4",  a_ifid_pc4,   32'hC);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("adv_pc",   a_pc,         32'h10);

        // Misaligned redirect at pc=16.
        step(1'b0, 1'b0, 1'b1, 32'h0000_0043);
        check("rd_pc",    a_pc,         32'h40);
        check("rd_valid", 32'(a_ifid_valid), 32'h0);
        check("rd_instr", a_ifid_instr, 32'h0);
        check("rd_bub",   32'(a_bubble_count), 32'd1);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("rd_pc4",   a_ifid_pc4,   32'h44);
        check("rd_v1",    32'(a_ifid_valid), 32'h1);

        // Redirect and stall together: redirect wins, no stall counted.
        step(1'b0, 1'b1, 1'b1, 32'h100);
        check("rs_pc",    a_pc,         32'h100);
        check("rs_stall", 32'(a_stall_count), 32'd3);
        check("rs_bub",   32'(a_bubble_count), 32'd2);

        // Wrap from the top of the address space.
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("wr_pc",    a_pc,         32'h0);
        check("wr_pc4",   a_ifid_pc4,   32'h0);
        check("wr_valid", 32'(a_ifid_valid), 32'h1);

        // Back-to-back redirects.
        step(1'b0, 1'b0, 1'b1, 32'h200);
        step(1'b0, 1'b0, 1'b1, 32'h301);
        check("rr_pc",    a_pc,         32'h300);

        // Reset during a stall with pc=0x20, then counter saturation.
        step(1'b0, 1'b0, 1'b1, 32'h20);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        check("pre_rst_pc", a_pc, 32'h20);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        check("mid_rst_pc",  a_pc, RESET_PC);
        check("mid_rst_st",  32'(a_stall_count),  32'h0);
        check("mid_rst_bub", 32'(a_bubble_count), 32'h0);
        repeat (5) step(1'b0, 1'b1, 1'b0, 32'h0);
        check("sat_small", 32'(b_stall_count), 32'd3);
        check("sat_big",   32'(a_stall_count), 32'd5);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("post_rst_pc4", a_ifid_pc4, RESET_PC + 32'd4);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic r, s, rd;
            r  = ($urandom_range(99) < 3);
            s  = ($urandom_range(99) < 25);
            rd = ($urandom_range(99) < 15);
            step(r, s, rd, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
